sdr_rd: RTL and testbench
=========================

Name: sdr_rd

Overview:
Single-access SDRAM read sequencer. It is the read-side counterpart to the write sequencer on the same SDRAM command bus. On a request it issues ACTIVE, then READ, then captures a BURST_LEN-beat burst after CAS latency, then issues PRECHARGE. When tRP has elapsed it pulses rd_exit so the top-level arbiter can hand the bus back. It is driven by the same 167 MHz controller clock as the other sdr_* sequencers.

Parameters:
NRCD, 3, ACTIVE-to-READ spacing in clocks (tRCD/tCK rounded up); must be >=1
CAS_LAT, 3, CAS latency in clocks; must match the mode register; 2 or 3
BURST_LEN, 4, beats per read; must match the mode register; 1, 2, 4 or 8
NRP, 3, PRECHARGE-to-exit spacing in clocks (tRP/tCK rounded up); must be >=1

Ports:
clk  input  1  controller clock, 167 MHz
rst_n  input  1  asynchronous active-low reset
sdr_rd_req  input  1  single-cycle read request; sampled only while idle
sdr_bank_addr  input  2  bank, latched on the accepted request
sdr_row_addr  input  13  row, latched on the accepted request
sdr_col_addr  input  9  start column, latched on the accepted request
sdr_CKE  output  1  constant 1
sdr_nCS  output  1  constant 0
sdr_BA  output  2  registered bank
sdr_A  output  13  registered address
sdr_nRAS  output  1  registered command bit
sdr_nCAS  output  1  registered command bit
sdr_nWE  output  1  registered command bit
sdr_DQ  input  16  SDRAM data bus (read side; not driven by this block)
sdr_DQM  output  2  constant 2'b00
rd_data  output  16  captured beat
rd_data_valid  output  1  one pulse per captured beat
rd_busy  output  1  high while a read is in progress
rd_exit  output  1  one-cycle pulse marking read completion

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state S_IDLE
  - {nRAS,nCAS,nWE}=NOP 3'b111
  - sdr_BA=0, sdr_A=0
  - rd_data=0, rd_data_valid=0, rd_busy=0, rd_exit=0
  - all counters cleared
  - reset during any phase aborts the access; no PRECHARGE is issued.
- Command encodings: NOP 111, ACTIVE 011, READ 101, PRECHARGE 010. Every command is held for exactly one cycle; NOP is driven in all other cycles.
- States: S_IDLE, S_ACTIVE, S_READ, S_CAPTURE, S_PRECHARGE. A single 16-bit cycle counter is cleared on every state transition.
- Cycle numbering: cycle 0 is the clock edge that samples sdr_rd_req high while in S_IDLE. All following times are output-visible cycles.
  - Cycle 1: ACTIVE on the bus. sdr_BA=bank, sdr_A=row. rd_busy rises and stays high through the rd_exit cycle inclusive.
  - Cycle r=1+NRCD: READ on the bus. sdr_A={4'b0000,col}, so A10=0 (no auto-precharge).
  - Beat k (k=0..BURST_LEN-1) is present on sdr_DQ in cycle r+CAS_LAT+k and is registered into rd_data. rd_data_valid is high in cycle r+CAS_LAT+k+1; pulses are contiguous.
  - rd_data holds its last value between bursts.
  - Cycle p=r+CAS_LAT+BURST_LEN: PRECHARGE on the bus. sdr_BA is unchanged and sdr_A[10]=0 (single bank).
  - Cycle p+NRP: rd_exit=1 for one cycle. State returns to S_IDLE on the following edge.
- sdr_rd_req is ignored whenever rd_busy=1, including the rd_exit cycle. A new request is accepted from the first cycle after rd_exit.
- Address and bank are latched only on the accepted request. Input changes mid-access have no effect.
- No row-open tracking: every access is a full ACTIVE / READ / PRECHARGE sequence.
- Illegal state encodings recover to S_IDLE with NOP.

Test Plan:
1. Defaults, req at cycle 0 with bank=2, row=0x1ABC, col=0x0F3 -> ACTIVE cycle 1 (BA=2, A=0x1ABC); READ cycle 4 (A=0x00F3); PRECHARGE cycle 11; rd_exit cycle 14; rd_busy high cycles 1-14.
2. Bench model drives 0x1111, 0x2222, 0x3333, 0x4444 on sdr_DQ in cycles 7-10 -> rd_data_valid high cycles 8-11 with rd_data equal to those words in order.
3. Second req held high during cycles 2-14, then a new req at cycle 15 -> no command issued before cycle 16; second ACTIVE at cycle 16.
4. Address inputs changed at cycle 3 -> READ still carries the cycle-0 column; sdr_BA stays at the cycle-0 bank through PRECHARGE.
5. rst_n asserted at cycle 9 (mid-capture) -> outputs at reset values immediately, no PRECHARGE issued; after release, a new req starts a clean sequence at ACTIVE.
6. CAS_LAT=2, BURST_LEN=1, NRCD=2, NRP=2 -> ACTIVE cycle 1, READ cycle 3, valid cycle 6, PRECHARGE cycle 6, rd_exit cycle 8.

Source files
------------

// File: rtl/sdr_rd.sv
// -----------------------------------------------------------------------------
// sdr_rd -- single-access SDRAM read sequencer.
//
// On an accepted request it drives ACTIVE, waits NRCD clocks, drives READ
// (no auto-precharge), registers BURST_LEN beats from sdr_DQ once CAS_LAT has
// elapsed, drives PRECHARGE, waits NRP clocks and pulses rd_exit so the
// arbiter can hand the command bus to another sequencer.
//
// Ports:
//   clk, rst_n        controller clock, asynchronous active-low reset
//   sdr_rd_req        one-cycle request, only looked at while idle
//   sdr_bank_addr     bank        (latched on the accepted request)
//   sdr_row_addr      row         (latched on the accepted request)
//   sdr_col_addr      start col   (latched on the accepted request)
//   sdr_CKE/nCS/DQM   constant SDRAM control levels
//   sdr_BA, sdr_A     registered bank / address
//   sdr_nRAS/nCAS/nWE registered command
//   sdr_DQ            read data from the SDRAM
//   rd_data           last captured beat (held between bursts)
//   rd_data_valid     one pulse per captured beat
//   rd_busy           high from ACTIVE through the rd_exit cycle
//   rd_exit           one-cycle completion pulse
// -----------------------------------------------------------------------------
module sdr_rd #(
  parameter int NRCD      = 3,
  parameter int CAS_LAT   = 3,
  parameter int BURST_LEN = 4,
  parameter int NRP       = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdr_rd_req,
  input  logic [1:0]  sdr_bank_addr,
  input  logic [12:0] sdr_row_addr,
  input  logic [8:0]  sdr_col_addr,
  output logic        sdr_CKE,
  output logic        sdr_nCS,
  output logic [1:0]  sdr_BA,
  output logic [12:0] sdr_A,
  output logic        sdr_nRAS,
  output logic        sdr_nCAS,
  output logic        sdr_nWE,
  input  logic [15:0] sdr_DQ,
  output logic [1:0]  sdr_DQM,
  output logic [15:0] rd_data,
  output logic        rd_data_valid,
  output logic        rd_busy,
  output logic        rd_exit
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ACTIVE    = 3'd1,
    S_READ      = 3'd2,
    S_CAPTURE   = 3'd3,
    S_PRECHARGE = 3'd4
  } state_e;

  // {nRAS, nCAS, nWE}
  localparam logic [2:0] CMD_NOP       = 3'b111;
  localparam logic [2:0] CMD_ACTIVE    = 3'b011;
  localparam logic [2:0] CMD_READ      = 3'b101;
  localparam logic [2:0] CMD_PRECHARGE = 3'b010;

  // Counter values at which each phase ends. The counter restarts at 0 on
  // every state change, so "last" is the phase length minus one.
  localparam logic [15:0] RCD_LAST   = 16'(NRCD - 1);
  localparam logic [15:0] CAS_LAST   = 16'(CAS_LAT - 1);
  localparam logic [15:0] BURST_LAST = 16'(BURST_LEN - 1);
  localparam logic [15:0] RP_LAST    = 16'(NRP - 1);
  localparam logic [15:0] RP_DONE    = 16'(NRP);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [1:0]  ba_q, ba_d;
  logic [12:0] a_q, a_d;
  logic [8:0]  col_q, col_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        exit_q, exit_d;

  // Commands are decided on the edge that changes state, so each command is
  // on the bus in the first cycle of its phase and NOP everywhere else.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    cmd_d   = CMD_NOP;
    ba_d    = ba_q;
    a_d     = a_q;
    col_d   = col_q;
    data_d  = data_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    exit_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (sdr_rd_req) begin
          state_d = S_ACTIVE;
          cmd_d   = CMD_ACTIVE;
          ba_d    = sdr_bank_addr;
          a_d     = sdr_row_addr;
          col_d   = sdr_col_addr;
          busy_d  = 1'b1;
        end
      end

      S_ACTIVE: begin
        if (cnt_q == RCD_LAST) begin
          state_d = S_READ;
          cnt_d   = '0;
          cmd_d   = CMD_READ;
          // A10 low: no auto-precharge, PRECHARGE is issued explicitly.
          a_d     = {4'b0000, col_q};
        end
      end

      S_READ: begin
        // Wait out CAS latency; the first beat arrives on the next edge.
        if (cnt_q == CAS_LAST) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end
      end

      S_CAPTURE: begin
        data_d  = sdr_DQ;
        valid_d = 1'b1;
        // The last beat and PRECHARGE share an edge.
        if (cnt_q == BURST_LAST) begin
          state_d   = S_PRECHARGE;
          cnt_d     = '0;
          cmd_d     = CMD_PRECHARGE;
          a_d[10]   = 1'b0;
        end
      end

      S_PRECHARGE: begin
        if (cnt_q == RP_LAST) begin
          exit_d = 1'b1;
        end
        // Stay one more cycle so the request seen during rd_exit is ignored.
        if (cnt_q == RP_DONE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= CMD_NOP;
      ba_q    <= '0;
      a_q     <= '0;
      col_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      a_q     <= a_d;
      col_q   <= col_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      exit_q  <= exit_d;
    end
  end

  assign sdr_CKE                      = 1'b1;
  assign sdr_nCS                      = 1'b0;
  assign sdr_DQM                      = 2'b00;
  assign sdr_BA                       = ba_q;
  assign sdr_A                        = a_q;
  assign {sdr_nRAS, sdr_nCAS, sdr_nWE} = cmd_q;
  assign rd_data                      = data_q;
  assign rd_data_valid                = valid_q;
  assign rd_busy                      = busy_q;
  assign rd_exit                      = exit_q;

endmodule

// File: tb/tb_sdr_rd.sv
// -----------------------------------------------------------------------------
// tb_sdr_rd -- bench for sdr_rd. Two instances share the stimulus: one with
// default timing, one with NRCD=2, CAS_LAT=2, BURST_LEN=1, NRP=2. A per-cycle
// table of expected bus activity is filled in whenever the model decides a
// request is accepted, and every cycle is compared against it.
// -----------------------------------------------------------------------------
module tb_sdr_rd;

  localparam int NCYC = 800;
  localparam int N    = NCYC + 64;

  localparam logic [2:0] NOP = 3'b111;
  localparam logic [2:0] ACT = 3'b011;
  localparam logic [2:0] RD  = 3'b101;
  localparam logic [2:0] PRE = 3'b010;

  typedef struct {
    logic [2:0]  cmd;
    logic [12:0] a;
    logic [1:0]  ba;
    bit          busy;
    bit          ex;
    bit          vld;
    int          src;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [1:0]  bank;
  logic [12:0] row;
  logic [8:0]  col;
  logic [15:0] dq;

  logic [1:0]  cke, ncs, nras, ncas, nwe, vld, busy, ex;
  logic [1:0]  ba_o   [2];
  logic [12:0] a_o    [2];
  logic [1:0]  dqm_o  [2];
  logic [15:0] data_o [2];

  int p_nrcd [2] = '{3, 2};
  int p_cl   [2] = '{3, 2};
  int p_bl   [2] = '{4, 1};
  int p_nrp  [2] = '{3, 2};

  exp_t        tbl [2][N];
  logic [15:0] dq_hist [N];

  int n_pass  = 0;
  int n_total = 0;
  int cyc;
  int c0a = 4;
  int c1  = 730;

  always #5 clk = ~clk;

  sdr_rd u_dut0 (
    .clk(clk), .rst_n(rst_n), .sdr_rd_req(req),
    .sdr_bank_addr(bank), .sdr_row_addr(row), .sdr_col_addr(col),
    .sdr_CKE(cke[0]), .sdr_nCS(ncs[0]), .sdr_BA(ba_o[0]), .sdr_A(a_o[0]),
    .sdr_nRAS(nras[0]), .sdr_nCAS(ncas[0]), .sdr_nWE(nwe[0]),
    .sdr_DQ(dq), .sdr_DQM(dqm_o[0]),
    .rd_data(data_o[0]), .rd_data_valid(vld[0]), .rd_busy(busy[0]), .rd_exit(ex[0])
  );

  sdr_rd #(.NRCD(2), .CAS_LAT(2), .BURST_LEN(1), .NRP(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sdr_rd_req(req),
    .sdr_bank_addr(bank), .sdr_row_addr(row), .sdr_col_addr(col),
    .sdr_CKE(cke[1]), .sdr_nCS(ncs[1]), .sdr_BA(ba_o[1]), .sdr_A(a_o[1]),
    .sdr_nRAS(nras[1]), .sdr_nCAS(ncas[1]), .sdr_nWE(nwe[1]),
    .sdr_DQ(dq), .sdr_DQM(dqm_o[1]),
    .rd_data(data_o[1]), .rd_data_valid(vld[1]), .rd_busy(busy[1]), .rd_exit(ex[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [2:0] cmd_of(input int d);
    return {nras[d], ncas[d], nwe[d]};
  endfunction

  // Forget every expectation from cycle 'from' on (reset aborts the access).
  task automatic wipe(input int from);
    for (int d = 0; d < 2; d++)
      for (int i = from; i < N; i++)
        tbl[d][i] = '{cmd: NOP, a: '0, ba: '0, busy: 0, ex: 0, vld: 0, src: 0};
  endtask

  // Timeline of one access, relative to the cycle carrying the request.
  task automatic schedule(input int d, input int c0, input logic [1:0] b,
                          input logic [12:0] r, input logic [8:0] c);
    int rc, p, e;
    rc = 1 + p_nrcd[d];
    p  = rc + p_cl[d] + p_bl[d];
    e  = p + p_nrp[d];
    for (int k = 1; k <= e; k++) tbl[d][c0 + k].busy = 1;
    tbl[d][c0 + 1].cmd  = ACT; tbl[d][c0 + 1].a  = r;  tbl[d][c0 + 1].ba  = b;
    tbl[d][c0 + rc].cmd = RD;  tbl[d][c0 + rc].a = {4'b0000, c}; tbl[d][c0 + rc].ba = b;
    tbl[d][c0 + p].cmd  = PRE; tbl[d][c0 + p].ba = b;
    tbl[d][c0 + e].ex   = 1;
    for (int k = 0; k < p_bl[d]; k++) begin
      tbl[d][c0 + rc + p_cl[d] + k + 1].vld = 1;
      tbl[d][c0 + rc + p_cl[d] + k + 1].src = c0 + rc + p_cl[d] + k;
    end
  endtask

  task automatic check_reset_outputs(input string where);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s d%0d cmd", where, d), 32'(cmd_of(d)), 32'(NOP));
      check($sformatf("%s d%0d ba", where, d), 32'(ba_o[d]), 32'd0);
      check($sformatf("%s d%0d a", where, d), 32'(a_o[d]), 32'd0);
      check($sformatf("%s d%0d data", where, d), 32'(data_o[d]), 32'd0);
      check($sformatf("%s d%0d ctl", where, d), {28'd0, vld[d], busy[d], ex[d], 1'b0}, 32'd0);
    end
  endtask

  task automatic compare_cycle(input int i);
    for (int d = 0; d < 2; d++) begin
      exp_t x;
      x = tbl[d][i];
      check($sformatf("c%0d d%0d cmd", i, d), 32'(cmd_of(d)), 32'(x.cmd));
      check($sformatf("c%0d d%0d busy", i, d), 32'(busy[d]), 32'(x.busy));
      check($sformatf("c%0d d%0d exit", i, d), 32'(ex[d]), 32'(x.ex));
      check($sformatf("c%0d d%0d valid", i, d), 32'(vld[d]), 32'(x.vld));
      if (x.vld) check($sformatf("c%0d d%0d data", i, d), 32'(data_o[d]), 32'(dq_hist[x.src]));
      if (x.cmd == ACT || x.cmd == RD)
        check($sformatf("c%0d d%0d addr", i, d), 32'(a_o[d]), 32'(x.a));
      if (x.cmd == PRE)
        check($sformatf("c%0d d%0d a10", i, d), 32'(a_o[d][10]), 32'd0);
      if (x.cmd != NOP)
        check($sformatf("c%0d d%0d bank", i, d), 32'(ba_o[d]), 32'(x.ba));
    end
  endtask

  // Literal timings for the default instance and the short-timing instance.
  task automatic directed_a(input int rel);
    case (rel)
      1: begin
        check("A act0", 32'(cmd_of(0)), 32'(ACT));
        check("A ba0", 32'(ba_o[0]), 32'd2);
        check("A row0", 32'(a_o[0]), 32'h1ABC);
        check("A act1", 32'(cmd_of(1)), 32'(ACT));
      end
      3: check("A rd1", 32'(cmd_of(1)), 32'(RD));
      4: begin
        check("A rd0", 32'(cmd_of(0)), 32'(RD));
        check("A col0", 32'(a_o[0]), 32'h00F3);
      end
      6: begin
        check("A vld1", 32'(vld[1]), 32'd1);
        check("A pre1", 32'(cmd_of(1)), 32'(PRE));
      end
      8: check("A exit1", 32'(ex[1]), 32'd1);
      11: begin
        check("A pre0", 32'(cmd_of(0)), 32'(PRE));
        check("A preba0", 32'(ba_o[0]), 32'd2);
      end
      14: check("A exit0", 32'(ex[0]), 32'd1);
      15: check("A idle0", {30'd0, busy[0], ex[0]}, 32'd0);
      16: check("A act0b", 32'(cmd_of(0)), 32'(ACT));
      default: ;
    endcase
    if (rel >= 8 && rel <= 11) begin
      check($sformatf("A vld0 %0d", rel), 32'(vld[0]), 32'd1);
      check($sformatf("A data0 %0d", rel), 32'(data_o[0]), 32'(16'h1111 * 16'(rel - 7)));
    end
  endtask

  initial begin
    wipe(0);
    rst_n = 1'b0; req = 1'b0; bank = '0; row = '0; col = '0; dq = '0;
    #12;
    check_reset_outputs("por");
    check("const ctl", {28'd0, cke, ncs}, {28'd0, 2'b11, 2'b00});
    check("const dqm", {28'd0, dqm_o[0], dqm_o[1]}, 32'd0);
    #1 rst_n = 1'b1;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      int rel;
      @(posedge clk);
      #1;
      rel = cyc - c0a;
      req  = 1'b0;
      bank = 2'($urandom);
      row  = 13'($urandom);
      col  = 9'($urandom);
      dq   = 16'($urandom);

      if (cyc < 40) begin
        req = (rel == 0) || (rel >= 2 && rel <= 15);
        if (rel < 3) begin
          bank = 2'd2; row = 13'h1ABC; col = 9'h0F3;
        end
        if (rel >= 7 && rel <= 10) dq = 16'h1111 * 16'(rel - 6);
      end else if (cyc < 700) begin
        req = ($urandom_range(0, 2) == 0);
      end else begin
        req = (cyc == c1) || (cyc == c1 + 15);
        if (cyc == c1 + 9) begin
          #1 rst_n = 1'b0;
          #1 check_reset_outputs("midrst");
          wipe(cyc);
        end
        if (cyc == c1 + 12) rst_n = 1'b1;
      end
      dq_hist[cyc] = dq;

      if (req && rst_n)
        for (int d = 0; d < 2; d++)
          if (!tbl[d][cyc].busy) schedule(d, cyc, bank, row, col);

      @(negedge clk);
      compare_cycle(cyc);
      if (cyc < 40) directed_a(rel);
      if (cyc == c1 + 16) check("C act0", 32'(cmd_of(0)), 32'(ACT));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
